tick_debouncer: RTL and testbench
=================================

TICK_DEBOUNCER -- requirements
Module: tick_debouncer

Interface
REQ-001 Parameter SAMPLES, default 3, is the number of consecutive tick pulses the synchronized input must stay stable before the output changes; legal range 1..15.
REQ-002 Parameter CNT_W, default 8, is the width of press_count.
REQ-003 Port clk, input, 1, is the single clock; all state updates on the rising edge.
REQ-004 Port reset, input, 1, is the asynchronous, active-low reset (0 = reset asserted).
REQ-005 Port tick, input, 1, is the sampling strobe from the upstream free-running counter's max_tick; each cycle with tick=1 counts as one sample.
REQ-006 Port sw, input, 1, is the raw asynchronous switch/button level.
REQ-007 Port clr, input, 1, is a synchronous clear of press_count.
REQ-008 Port db_level, output, 1, is the debounced level.
REQ-009 Port db_rise, output, 1, is a one-cycle pulse on each debounced 0->1 transition.
REQ-010 Port db_fall, output, 1, is a one-cycle pulse on each debounced 1->0 transition.
REQ-011 Port press_count, output, CNT_W, is the number of debounced rising edges.

Function
REQ-012 sw SHALL pass through a 2-flop synchronizer; sw_s (second flop) is the only sw value used by the FSM.
REQ-013 FSM states SHALL be ZERO, WAIT1, ONE and WAIT0, with a 4-bit down-counter k.
REQ-014 ZERO: sw_s=1 -> WAIT1 with k<=SAMPLES-1; else stay.
REQ-015 WAIT1: sw_s=0 -> ZERO (priority over tick); else tick=1 and k=0 -> ONE; else tick=1 -> k<=k-1; else hold.
REQ-016 ONE: sw_s=0 -> WAIT0 with k<=SAMPLES-1; else stay.
REQ-017 WAIT0: sw_s=1 -> ONE (priority over tick); else tick=1 and k=0 -> ZERO; else tick=1 -> k<=k-1; else hold.
REQ-018 A transition from WAITx SHALL require SAMPLES tick cycles, all with sw_s stable, while in WAITx; a tick in the cycle the WAIT state is entered is not counted.
REQ-019 db_level SHALL be registered: 1 in states ONE and WAIT0, 0 in ZERO and WAIT1.
REQ-020 db_rise SHALL be high for exactly the first clock cycle in which the state is ONE after WAIT1; db_fall likewise for ZERO after WAIT0; they are never high together.
REQ-021 WAIT0->ONE and WAIT1->ZERO bounces SHALL NOT pulse db_rise or db_fall.
REQ-022 press_count SHALL increment by 1 in the cycle db_rise is asserted and wrap from 2^CNT_W-1 to 0 without a flag.
REQ-023 clr=1 SHALL set press_count to 0 on the next edge; clr wins over a simultaneous increment.
REQ-024 tick held high continuously SHALL count one sample per cycle (no edge detection on tick).
REQ-025 Latency from sw edge to db_level change, with sw stable, SHALL be 2 sync cycles + 1 cycle to enter WAITx + the cycles up to and including the SAMPLES-th subsequent tick + 1 cycle.

Reset
REQ-026 While reset=0: synchronizer flops 0, state ZERO, k=0, db_level=0, db_rise=0, db_fall=0, press_count=0, asynchronously.
REQ-027 Reset asserted mid-WAIT SHALL abandon the partial count; after release the FSM restarts from ZERO and requires a full SAMPLES-tick window.
REQ-028 After reset release with sw held 1, db_rise SHALL pulse once when the debounce window completes.

Verification
REQ-029 SAMPLES=3, tick every 8 cycles, sw 0->1 stable -> db_level=1 and a single db_rise on the third tick after entering WAIT1 (+1 cycle); press_count=1.
REQ-030 sw pulses 1 for 10 cycles with tick every 8 -> at most 1 tick counted, state returns to ZERO, db_level stays 0, no pulses.
REQ-031 From ONE, sw drops to 0 for 2 ticks then returns 1 -> WAIT0->ONE, db_level stays 1, no db_fall, no db_rise.
REQ-032 CNT_W=8, press_count=255, one clean press -> press_count=0; clr asserted in the db_rise cycle -> press_count=0.
REQ-033 reset=0 asserted during WAIT1 after 2 ticks -> all outputs 0 immediately; after release, 3 full ticks are required before db_rise.
REQ-034 tick tied to 1, SAMPLES=1, sw 0->1 -> db_level=1 exactly 5 cycles after the sw edge.

Source files
------------

// File: rtl/tick_debouncer.sv
// rtl/tick_debouncer.sv - switch debouncer sampled by an external tick strobe
// Counts debounced presses; outputs are registered and aligned with db_level.
module tick_debouncer #(
   parameter int SAMPLES = 3,
   parameter int CNT_W   = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             tick,
   input  logic             sw,
   input  logic             clr,
   output logic             db_level,
   output logic             db_rise,
   output logic             db_fall,
   output logic [CNT_W-1:0] press_count
);

   typedef enum logic [1:0] {ZERO, WAIT1, ONE, WAIT0} state_t;

   localparam logic [3:0] K_INIT = 4'(SAMPLES - 1);

   state_t     state;
   state_t     state_next;
   logic [3:0] k;
   logic [3:0] k_next;
   logic       sw_m;
   logic       sw_s;
   logic       level_next;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         sw_m <= 1'b0;
         sw_s <= 1'b0;
      end else begin
         sw_m <= sw;
         sw_s <= sw_m;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= ZERO;
         k     <= 4'd0;
      end else begin
         state <= state_next;
         k     <= k_next;
      end
   end

   // A bounce back to the old level always beats a tick in the same cycle.
   always_comb begin
      state_next = state;
      k_next     = k;
      case (state)
         ZERO: begin
            if (sw_s) begin
               state_next = WAIT1;
               k_next     = K_INIT;
            end
         end
         WAIT1: begin
            if (!sw_s) begin
               state_next = ZERO;
            end else if (tick) begin
               if (k == 4'd0) state_next = ONE;
               else           k_next     = k - 4'd1;
            end
         end
         ONE: begin
            if (!sw_s) begin
               state_next = WAIT0;
               k_next     = K_INIT;
            end
         end
         WAIT0: begin
            if (sw_s) begin
               state_next = ONE;
            end else if (tick) begin
               if (k == 4'd0) state_next = ZERO;
               else           k_next     = k - 4'd1;
            end
         end
         default: begin
            state_next = ZERO;
            k_next     = 4'd0;
         end
      endcase
   end

   assign level_next = (state == ONE) || (state == WAIT0);

   // Edges are taken against the registered level, so bounces never pulse.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_level    <= 1'b0;
         db_rise     <= 1'b0;
         db_fall     <= 1'b0;
         press_count <= '0;
      end else begin
         db_level <= level_next;
         db_rise  <= level_next & ~db_level;
         db_fall  <= ~level_next & db_level;
         if (clr)
            press_count <= '0;
         else if (db_rise)
            press_count <= press_count + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_tick_debouncer.sv
// tb/tb_tick_debouncer.sv - directed self-checking bench for tick_debouncer
module tb_tick_debouncer;

   logic       clk = 1'b0;
   logic       reset = 1'b0;
   logic       tick = 1'b0;
   logic       sw = 1'b0;
   logic       clr = 1'b0;
   logic       db_level, db_rise, db_fall;
   logic [7:0] press_count;

   logic       tick1 = 1'b1;
   logic       sw1 = 1'b0;
   logic       clr1 = 1'b0;
   logic       db_level1, db_rise1, db_fall1;
   logic [7:0] press_count1;

   int n_chk = 0;
   int n_bad = 0;
   int n_rise = 0;
   int n_fall = 0;
   int n_both = 0;
   int base_rise, base_fall;

   tick_debouncer #(.SAMPLES(3), .CNT_W(8)) u_dut (
      .clk(clk), .reset(reset), .tick(tick), .sw(sw), .clr(clr),
      .db_level(db_level), .db_rise(db_rise), .db_fall(db_fall),
      .press_count(press_count)
   );

   tick_debouncer #(.SAMPLES(1), .CNT_W(8)) u_dut1 (
      .clk(clk), .reset(reset), .tick(tick1), .sw(sw1), .clr(clr1),
      .db_level(db_level1), .db_rise(db_rise1), .db_fall(db_fall1),
      .press_count(press_count1)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (db_rise) n_rise++;
      if (db_fall) n_fall++;
      if (db_rise && db_fall) n_both++;
   end

   task automatic chk(input string tag, input int got, input int exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic cyc(input logic t);
      tick = t;
      @(posedge clk);
      #1;
   endtask

   task automatic tick_period();
      repeat (7) cyc(1'b0);
      cyc(1'b1);
   endtask

   task automatic press();
      sw = 1'b1;
      repeat (8) cyc(1'b1);
      sw = 1'b0;
      repeat (8) cyc(1'b1);
   endtask

   initial begin
      repeat (3) cyc(1'b0);
      chk("reset_level", db_level, 0);
      chk("reset_rise", db_rise, 0);
      chk("reset_fall", db_fall, 0);
      chk("reset_count", press_count, 0);
      reset = 1'b1;
      cyc(1'b0);

      // short glitch: at most one tick counted, no output activity
      base_rise = n_rise; base_fall = n_fall;
      sw = 1'b1;
      for (int i = 0; i < 10; i++) cyc(i == 7);
      sw = 1'b0;
      for (int i = 0; i < 20; i++) cyc((i % 8) == 7);
      chk("glitch_level", db_level, 0);
      chk("glitch_rise", n_rise - base_rise, 0);
      chk("glitch_fall", n_fall - base_fall, 0);

      // clean press: level follows the third tick by one cycle
      base_rise = n_rise;
      sw = 1'b1;
      repeat (3) cyc(1'b0);
      tick_period();
      tick_period();
      chk("press_before_3rd", db_level, 0);
      tick_period();
      chk("press_at_3rd", db_level, 0);
      cyc(1'b0);
      chk("press_level", db_level, 1);
      chk("press_rise", db_rise, 1);
      chk("press_count_lag", press_count, 0);
      cyc(1'b0);
      chk("press_rise_end", db_rise, 0);
      chk("press_count", press_count, 1);
      chk("press_single_rise", n_rise - base_rise, 1);

      // bounce in WAIT0 returns to ONE silently
      base_rise = n_rise; base_fall = n_fall;
      sw = 1'b0;
      repeat (3) cyc(1'b0);
      tick_period();
      tick_period();
      sw = 1'b1;
      repeat (10) cyc(1'b0);
      chk("bounce_level", db_level, 1);
      chk("bounce_rise", n_rise - base_rise, 0);
      chk("bounce_fall", n_fall - base_fall, 0);

      // clean release
      sw = 1'b0;
      repeat (3) cyc(1'b0);
      repeat (3) tick_period();
      chk("release_lag", db_level, 1);
      cyc(1'b0);
      chk("release_level", db_level, 0);
      chk("release_fall", db_fall, 1);
      chk("release_no_rise", db_rise, 0);
      chk("release_count", press_count, 1);

      // counter wrap with tick held high
      for (int i = 0; i < 254; i++) press();
      chk("count_255", press_count, 255);
      press();
      chk("count_wrap", press_count, 0);
      press();
      chk("count_after_wrap", press_count, 1);

      // clr in the db_rise cycle beats the increment
      sw = 1'b1;
      repeat (6) cyc(1'b1);
      chk("tickhi_level_pre", db_level, 0);
      cyc(1'b1);
      chk("tickhi_level", db_level, 1);
      chk("clr_rise_cycle", db_rise, 1);
      clr = 1'b1;
      cyc(1'b1);
      clr = 1'b0;
      chk("clr_wins", press_count, 0);
      sw = 1'b0;
      repeat (8) cyc(1'b1);
      press();
      chk("count_after_clr", press_count, 1);

      // reset in WAIT1 after two ticks abandons the window
      sw = 1'b1;
      repeat (3) cyc(1'b0);
      tick_period();
      tick_period();
      reset = 1'b0;
      #2;
      chk("async_rst_count", press_count, 0);
      chk("async_rst_level", db_level, 0);
      chk("async_rst_rise", db_rise, 0);
      chk("async_rst_fall", db_fall, 0);
      cyc(1'b1);
      cyc(1'b1);
      reset = 1'b1;
      base_rise = n_rise;
      repeat (3) cyc(1'b0);
      tick_period();
      tick_period();
      chk("rst_two_ticks_level", db_level, 0);
      chk("rst_two_ticks_rise", n_rise - base_rise, 0);
      tick_period();
      cyc(1'b0);
      chk("rst_full_level", db_level, 1);
      chk("rst_full_rise", db_rise, 1);
      cyc(1'b0);
      chk("rst_full_count", press_count, 1);

      // SAMPLES=1, tick tied high: level exactly 5 cycles after sw edge
      sw1 = 1'b1;
      for (int i = 1; i <= 4; i++) begin
         cyc(1'b0);
         chk($sformatf("s1_level_c%0d", i), db_level1, 0);
      end
      cyc(1'b0);
      chk("s1_level_c5", db_level1, 1);
      chk("s1_rise_c5", db_rise1, 1);

      chk("rise_fall_overlap", n_both, 0);
      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule
